// File: rtl/lcd_refresh.sv
// HD44780 16x2 refresh engine: powers up and initialises the panel, then on each
// start copies the 32-byte character memory to both display lines.
module lcd_refresh #(
  parameter int E_HIGH_CYC    = 4,
  parameter int CMD_WAIT_CYC  = 100,
  parameter int LONG_WAIT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [4:0] mem_addr,
  output logic [1:0] mem_rw,
  input  logic [7:0] mem_rdata,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [15:0] E_LAST    = 16'(E_HIGH_CYC - 1);
  localparam logic [15:0] CMD_LAST  = 16'(CMD_WAIT_CYC - 1);
  localparam logic [15:0] LONG_LAST = 16'(LONG_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_PWR, S_IDLE, S_RDREQ, S_RDCAP, S_SETUP, S_PULSE, S_WAIT
  } state_t;

  // What the shared write sub-sequence returns to once its wait expires.
  typedef enum logic [1:0] {K_INIT, K_LINE1, K_CHAR, K_LINE2} kind_t;

  state_t      state, state_n;
  kind_t       kind, kind_n;
  logic [15:0] cnt, cnt_n, wait_last;
  logic [4:0]  idx, idx_n;
  logic [1:0]  ii, ii_n;
  logic        rs, rs_n;
  logic [7:0]  db, db_n;
  logic        fd, fd_n;

  function automatic logic [7:0] init_cmd(input logic [1:0] k);
    case (k)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear display needs the long settle time; everything else uses the short one.
  assign wait_last = (!rs && db == 8'h01) ? LONG_LAST : CMD_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_PWR;
      kind  <= K_INIT;
      cnt   <= '0;
      idx   <= '0;
      ii    <= '0;
      rs    <= 1'b0;
      db    <= 8'h00;
      fd    <= 1'b0;
    end else begin
      state <= state_n;
      kind  <= kind_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      ii    <= ii_n;
      rs    <= rs_n;
      db    <= db_n;
      fd    <= fd_n;
    end
  end

  always_comb begin
    state_n = state;
    kind_n  = kind;
    cnt_n   = cnt;
    idx_n   = idx;
    ii_n    = ii;
    rs_n    = rs;
    db_n    = db;
    fd_n    = 1'b0;
    case (state)
      S_PWR: begin
        if (cnt == LONG_LAST) begin
          cnt_n   = '0;
          state_n = S_SETUP;
          kind_n  = K_INIT;
          ii_n    = 2'd0;
          rs_n    = 1'b0;
          db_n    = init_cmd(2'd0);
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_IDLE: begin
        if (start) begin
          state_n = S_SETUP;
          kind_n  = K_LINE1;
          idx_n   = 5'd0;
          rs_n    = 1'b0;
          db_n    = 8'h80;
        end
      end
      S_RDREQ: state_n = S_RDCAP;
      S_RDCAP: begin
        state_n = S_SETUP;
        kind_n  = K_CHAR;
        rs_n    = 1'b1;
        db_n    = mem_rdata;
      end
      S_SETUP: begin
        cnt_n   = '0;
        state_n = S_PULSE;
      end
      S_PULSE: begin
        if (cnt == E_LAST) begin
          cnt_n   = '0;
          state_n = S_WAIT;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_WAIT: begin
        if (cnt == wait_last) begin
          cnt_n = '0;
          case (kind)
            K_INIT: begin
              if (ii == 2'd3) begin
                state_n = S_IDLE;
              end else begin
                ii_n    = ii + 2'd1;
                state_n = S_SETUP;
                rs_n    = 1'b0;
                db_n    = init_cmd(ii + 2'd1);
              end
            end
            K_LINE1, K_LINE2: state_n = S_RDREQ;
            K_CHAR: begin
              if (idx == 5'd31) begin
                idx_n   = 5'd0;
                fd_n    = 1'b1;
                state_n = S_IDLE;
              end else if (idx == 5'd15) begin
                idx_n   = 5'd16;
                kind_n  = K_LINE2;
                state_n = S_SETUP;
                rs_n    = 1'b0;
                db_n    = 8'hC0;
              end else begin
                idx_n   = idx + 5'd1;
                state_n = S_RDREQ;
              end
            end
            default: state_n = S_IDLE;
          endcase
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = S_PWR;
    endcase
  end

  assign mem_addr   = idx;
  assign mem_rw     = (state == S_RDREQ) ? 2'b11 : 2'b00;
  assign lcd_rs     = rs;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = (state == S_PULSE);
  assign lcd_db     = db;
  assign busy       = (state != S_IDLE);
  assign frame_done = fd;

endmodule

// File: tb/tb_lcd_refresh.sv
// Bench for lcd_refresh: a timeline model built from write/read costs predicts every
// LCD write, memory read and frame_done; monitors record what the DUT actually did.
module tb_lcd_refresh;
  localparam int E  = 4;
  localparam int CW = 100;
  localparam int LW = 1000;

  typedef struct packed { logic rs; logic [7:0] db; logic [31:0] t; } wr_t;
  typedef struct packed { logic [4:0] a; logic [31:0] t; } rd_t;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [4:0] mem_addr;
  logic [1:0] mem_rw;
  logic [7:0] mem_rdata;
  logic       lcd_rs, lcd_rw, lcd_e, busy, frame_done;
  logic [7:0] lcd_db;

  lcd_refresh #(.E_HIGH_CYC(E), .CMD_WAIT_CYC(CW), .LONG_WAIT_CYC(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_db(lcd_db), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [32];
  logic [31:0] cyc = '0;
  int checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rw == 2'b11) mem_rdata <= mem[mem_addr];

  // Observation queues
  wr_t wq[$], exp_w[$];
  rd_t rq[$], exp_r[$];
  int unsigned wdq[$], fdq[$], bq[$], chq[$];
  logic fdb[$];
  int bad_mem = 0, bad_rw = 0;
  logic e_prev = 1'b0, busy_prev = 1'b0;
  logic [8:0] dbs_prev = '0;
  logic [31:0] rise_t = '0;

  always @(negedge clk) begin
    if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
      wq.push_back('{lcd_rs, lcd_db, cyc});
      rise_t <= cyc;
    end
    if (lcd_e === 1'b0 && e_prev === 1'b1) wdq.push_back(cyc - rise_t);
    if (mem_rw === 2'b11) rq.push_back('{mem_addr, cyc});
    else if (mem_rw !== 2'b00) bad_mem <= bad_mem + 1;
    if (lcd_rw !== 1'b0) bad_rw <= bad_rw + 1;
    if (frame_done === 1'b1) begin fdq.push_back(cyc); fdb.push_back(busy); end
    if (busy === 1'b0 && busy_prev === 1'b1) bq.push_back(cyc);
    if ({lcd_rs, lcd_db} !== dbs_prev) chq.push_back(cyc);
    e_prev    <= lcd_e;
    busy_prev <= busy;
    dbs_prev  <= {lcd_rs, lcd_db};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_q();
    wq.delete(); rq.delete(); wdq.delete(); fdq.delete(); fdb.delete();
    bq.delete(); chq.delete(); exp_w.delete(); exp_r.delete();
    bad_mem = 0; bad_rw = 0;
  endtask

  function automatic int unsigned wcost(input logic rs, input logic [7:0] d);
    return 1 + E + ((!rs && d == 8'h01) ? LW : CW);
  endfunction

  // Power-up wait, then the four init commands back to back.
  task automatic build_init(input int unsigned t0);
    logic [7:0] cmds [4];
    int unsigned t;
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
    t = t0 + LW;
    for (int i = 0; i < 4; i++) begin
      exp_w.push_back('{1'b0, cmds[i], t + 1});
      t += wcost(1'b0, cmds[i]);
    end
  endtask

  // Frame timeline from its first SETUP cycle; returns the frame_done cycle.
  task automatic build_frame(input int unsigned s1, output int unsigned fd);
    int unsigned t;
    t = s1;
    exp_w.push_back('{1'b0, 8'h80, t + 1});
    t += wcost(1'b0, 8'h80);
    for (int i = 0; i < 32; i++) begin
      if (i == 16) begin
        exp_w.push_back('{1'b0, 8'hC0, t + 1});
        t += wcost(1'b0, 8'hC0);
      end
      exp_r.push_back('{5'(i), t});
      t += 2;
      exp_w.push_back('{1'b1, mem[i], t + 1});
      t += wcost(1'b1, mem[i]);
    end
    fd = t;
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < 32; i++) mem[i] = rnd ? 8'($urandom) : 8'h20;
    if (!rnd) begin mem[1] = 8'd13; mem[11] = 8'd11; end
  endtask

  task automatic check_all(input string tag);
    logic ok;
    chk({tag, "_nwr"}, 64'(wq.size()), 64'(exp_w.size()));
    foreach (exp_w[i])
      if (i < wq.size()) chk($sformatf("%s_wr%0d", tag, i), {23'b0, wq[i]}, {23'b0, exp_w[i]});
    chk({tag, "_nwidth"}, 64'(wdq.size()), 64'(exp_w.size()));
    foreach (wdq[i]) chk($sformatf("%s_ewidth%0d", tag, i), 64'(wdq[i]), 64'(E));
    chk({tag, "_nrd"}, 64'(rq.size()), 64'(exp_r.size()));
    foreach (exp_r[i])
      if (i < rq.size()) chk($sformatf("%s_rd%0d", tag, i), {27'b0, rq[i]}, {27'b0, exp_r[i]});
    chk({tag, "_memrw_illegal"}, 64'(bad_mem), 64'd0);
    chk({tag, "_lcdrw"}, 64'(bad_rw), 64'd0);
    // RS/DB may only change on a SETUP cycle.
    foreach (chq[i]) begin
      ok = 1'b0;
      foreach (exp_w[j]) if (exp_w[j].t == chq[i] + 1) ok = 1'b1;
      chk($sformatf("%s_dbstable%0d", tag, i), 64'(ok), 64'd1);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_memrw"}, 64'(mem_rw), 64'd0);
    chk({tag, "_rs"}, 64'(lcd_rs), 64'd0);
    chk({tag, "_rw"}, 64'(lcd_rw), 64'd0);
    chk({tag, "_e"}, 64'(lcd_e), 64'd0);
    chk({tag, "_db"}, 64'(lcd_db), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_fd"}, 64'(frame_done), 64'd0);
  endtask

  task automatic wait_fd(input int n, input int budget);
    for (int k = 0; k < budget && fdq.size() < n; k++) begin @(negedge clk); #1; end
    chk("fd_timeout", 64'(fdq.size() >= n), 64'd1);
  endtask

  // t0 = first cycle with rst low; optionally pokes start during power-up.
  task automatic run_init_check(input string tag, input int unsigned t0, input bit poke);
    @(negedge clk); #1;
    clear_q();
    build_init(t0);
    if (poke) begin
      repeat (200) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int k = 0; k < 3000 && busy !== 1'b0; k++) begin @(negedge clk); #1; end
    chk({tag, "_idle_timeout"}, 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    #1;
    chk({tag, "_nbusyfall"}, 64'(bq.size()), 64'd1);
    if (bq.size() > 0) chk({tag, "_busyfall_t"}, 64'(bq[0]), 64'(t0 + 2320));
    chk({tag, "_still_idle"}, 64'(busy), 64'd0);
    check_all(tag);
  endtask

  task automatic single_frame(input string tag);
    int unsigned s, fdt;
    @(posedge clk); #1;
    clear_q();
    start = 1'b1;
    s = cyc;
    build_frame(s + 1, fdt);
    @(posedge clk); #1 start = 1'b0;
    wait_fd(1, 4000);
    repeat (5) @(negedge clk);
    #1;
    chk({tag, "_nfd"}, 64'(fdq.size()), 64'd1);
    if (fdq.size() > 0) begin
      chk({tag, "_fd_t"}, 64'(fdq[0]), 64'(fdt));
      chk({tag, "_fd_busy"}, 64'(fdb[0]), 64'd0);
    end
    check_all(tag);
  endtask

  initial begin
    int unsigned t0, s, f1, f2;
    rst = 1'b1; start = 1'b0;
    fill_mem(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;
    t0 = cyc;
    run_init_check("init", t0, 1'b1);

    // Directed frame: line 1 = " \r         \v    ", line 2 = spaces.
    single_frame("dir");

    fill_mem(1'b1);
    single_frame("rnd");

    // start held across two frames, plus a stray mid-frame pulse.
    fill_mem(1'b1);
    @(posedge clk); #1;
    clear_q();
    start = 1'b1;
    s = cyc;
    build_frame(s + 1, f1);
    build_frame(f1 + 1, f2);
    wait_fd(1, 4000);
    @(posedge clk); #1 start = 1'b0;
    repeat (500) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_fd(2, 4000);
    repeat (300) @(negedge clk);
    #1;
    chk("held_nfd", 64'(fdq.size()), 64'd2);
    if (fdq.size() > 1) begin
      chk("held_fd0_t", 64'(fdq[0]), 64'(f1));
      chk("held_fd1_t", 64'(fdq[1]), 64'(f2));
      chk("held_fd0_busy", 64'(fdb[0]), 64'd0);
    end
    if (wq.size() > 34 && fdq.size() > 0)
      chk("held_gap_e_rise", 64'(wq[34].t - fdq[0]), 64'd2);
    chk("held_idle", 64'(busy), 64'd0);
    check_all("held");

    // Reset landing in the E pulse of character 20 (write #22).
    fill_mem(1'b1);
    @(posedge clk); #1;
    clear_q();
    start = 1'b1;
    s = cyc;
    build_frame(s + 1, f1);
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 4000 && wq.size() < 23; k++) begin @(negedge clk); #1; end
    chk("c20_timeout", 64'(wq.size() >= 23), 64'd1);
    if (wq.size() >= 23) chk("c20_wr", {23'b0, wq[22]}, {23'b0, exp_w[22]});
    chk("c20_e_high", 64'(lcd_e), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("midrst");
    rst = 1'b0;
    t0 = cyc;
    run_init_check("reinit", t0, 1'b0);
    chk("reinit_nofd", 64'(fdq.size()), 64'd0);

    fill_mem(1'b1);
    single_frame("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
